// File: rtl/clk_ratio_pkg.sv
// clk_ratio_pkg: shared definitions for the clock-ratio controller.
//   ch_state_e  : per-channel switch FSM encoding
//   RATIO_BASE  : first RATIO_i register; channel i sits at RATIO_BASE + 4*i
//   STATUS_OFF  : read-only busy vector
//   IRQSTAT_OFF : write-1-to-clear switch-done flags
//   word_of     : drops the byte-lane bits of an APB address
package clk_ratio_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_PRE = 2'b01,
    SETTLE   = 2'b10
  } ch_state_e;
  localparam logic [11:0] RATIO_BASE  = 12'h000;
  localparam logic [11:0] STATUS_OFF  = 12'h100;
  localparam logic [11:0] IRQSTAT_OFF = 12'h104;
  function automatic logic [9:0] word_of(input logic [11:0] a);
    return a[11:2];
  endfunction
endpackage

// File: rtl/clk_ratio_ch.sv
// clk_ratio_ch: one clock-enable channel with a glitch-free ratio switch.
//   per_clk   in   base clock
//   clkrst_b  in   asynchronous active-low reset
//   i_wr      in   accepted write to this channel's RATIO register
//   i_wdata   in   new ratio value (divide factor = value + 1)
//   o_clk_en  out  registered one-cycle enable pulse per period
//   o_busy    out  a ratio switch is pending or settling
//   o_done    out  one-cycle strobe on the SETTLE -> IDLE transition
//   o_rdata   out  RATIO readback: pending value while busy, else current
module clk_ratio_ch
  import clk_ratio_pkg::*;
#(
  parameter int DIV_W      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic             per_clk,
  input  logic             clkrst_b,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wdata,
  output logic             o_clk_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [DIV_W-1:0] o_rdata
);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);
  ch_state_e        r_state, w_state_n;
  logic [DIV_W-1:0] r_cnt, w_cnt_n;
  logic [DIV_W-1:0] r_cur, w_cur_n;
  logic [DIV_W-1:0] r_pend, w_pend_n;
  logic [SW-1:0]    r_scnt, w_scnt_n;
  logic             r_en;
  logic             w_term;
  assign w_term = r_cnt == r_cur;
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cur   <= '0;
      r_pend  <= '0;
      r_scnt  <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_cur   <= w_cur_n;
      r_pend  <= w_pend_n;
      r_scnt  <= w_scnt_n;
      r_en    <= w_term && r_state != SETTLE;
    end
  end
  // The switch is taken on the terminal count so the old period always
  // completes with its pulse; the counter is held at 0 while settling so a
  // full new period follows the settle gap.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_term ? '0 : r_cnt + DIV_W'(1);
    w_cur_n   = r_cur;
    w_pend_n  = r_pend;
    w_scnt_n  = r_scnt;
    o_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_wr && i_wdata != r_cur) begin
          w_pend_n  = i_wdata;
          w_state_n = WAIT_PRE;
        end
      end
      WAIT_PRE: begin
        if (w_term) begin
          w_cur_n   = r_pend;
          w_cnt_n   = '0;
          w_scnt_n  = '0;
          w_state_n = SETTLE;
        end
      end
      SETTLE: begin
        w_cnt_n  = '0;
        w_scnt_n = r_scnt + SW'(1);
        if (r_scnt == S_LAST) begin
          w_state_n = IDLE;
          o_done    = 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end
  assign o_clk_en = r_en;
  assign o_busy   = r_state != IDLE;
  assign o_rdata  = o_busy ? r_pend : r_cur;
endmodule

// File: rtl/clk_ratio_ctrl.sv
// clk_ratio_ctrl: APB-programmable multi-channel clock-enable generator.
//   per_clk    in   base clock; all logic in this domain
//   clkrst_b   in   asynchronous active-low reset
//   psel/penable/pwrite/paddr/pwdata  in  APB request (zero wait state)
//   prdata     out  read data, combinational, 0 unless psel & !pwrite
//   pready     out  tied 1
//   pslverr    out  error in the access phase: unmapped address, STATUS
//                   write, or RATIO_i write while channel i is busy
//   ch_clk_en  out  per-channel registered enable pulses
//   ch_busy    out  per-channel switch in progress
//   irq        out  registered OR of the switch-done flags
// Build option: define CLK_RATIO_IRQ_EN to implement IRQSTAT and irq;
// otherwise IRQSTAT reads 0, its writes are accepted and ignored, irq is 0.
module clk_ratio_ctrl
  import clk_ratio_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DIV_W      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic              per_clk,
  input  logic              clkrst_b,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [11:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] ch_clk_en,
  output logic [NUM_CH-1:0] ch_busy,
  output logic              irq
);
  logic [9:0]        w_word;
  logic [9:0]        w_roff;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_irqstat;
  logic [DIV_W-1:0]  w_rdata [NUM_CH];
  logic              w_ratio_hit, w_stat_hit, w_irq_hit;
  logic              w_acc, w_err, w_wr_ok;
  logic [31:0]       w_rmux;
  logic              w_unused;
  assign w_word      = word_of(paddr);
  assign w_roff      = w_word - word_of(RATIO_BASE);
  assign w_ratio_hit = |w_sel;
  assign w_stat_hit  = w_word == word_of(STATUS_OFF);
  assign w_irq_hit   = w_word == word_of(IRQSTAT_OFF);
  assign w_acc       = psel & penable;
  assign w_err       = !(w_ratio_hit | w_stat_hit | w_irq_hit)
                     | (pwrite & w_stat_hit)
                     | (pwrite & |(w_sel & ch_busy));
  assign w_wr_ok     = w_acc & pwrite & !w_err;
  assign pslverr     = w_acc & w_err;
  assign pready      = 1'b1;
  assign w_unused    = ^{paddr[1:0], pwdata[31:DIV_W]};
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_sel[g] = w_roff == 10'(g);
    clk_ratio_ch #(
      .DIV_W     (DIV_W),
      .SETTLE_CYC(SETTLE_CYC)
    ) u_ch (
      .per_clk (per_clk),
      .clkrst_b(clkrst_b),
      .i_wr    (w_wr_ok & w_sel[g]),
      .i_wdata (pwdata[DIV_W-1:0]),
      .o_clk_en(ch_clk_en[g]),
      .o_busy  (ch_busy[g]),
      .o_done  (w_done[g]),
      .o_rdata (w_rdata[g])
    );
  end
  always_comb begin
    w_rmux = '0;
    for (int i = 0; i < NUM_CH; i++) if (w_sel[i]) w_rmux = 32'(w_rdata[i]);
    if (w_stat_hit) w_rmux = 32'(ch_busy);
    if (w_irq_hit) w_rmux = 32'(w_irqstat);
  end
  assign prdata = (psel & !pwrite) ? w_rmux : '0;
`ifdef CLK_RATIO_IRQ_EN
  logic [NUM_CH-1:0] r_irqstat;
  logic [NUM_CH-1:0] w_clr;
  logic              r_irq;
  assign w_clr = (w_wr_ok & w_irq_hit) ? pwdata[NUM_CH-1:0] : '0;
  // A done strobe wins over a same-cycle W1C so no completion is lost.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      r_irqstat <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_irqstat <= (r_irqstat & ~w_clr) | w_done;
      r_irq     <= |r_irqstat;
    end
  end
  assign w_irqstat = r_irqstat;
  assign irq       = r_irq;
`else
  logic w_unused_done;
  assign w_unused_done = ^w_done;
  assign w_irqstat     = '0;
  assign irq           = 1'b0;
`endif
endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// tb_clk_ratio_ctrl: scoreboard bench with a schedule-based reference model.
module tb_clk_ratio_ctrl;
  localparam int NUM_CH = 2, DIV_W = 4, SETTLE_CYC = 2;
  logic per_clk = 0, clkrst_b = 0, psel = 0, penable = 0, pwrite = 0;
  logic [11:0] paddr = 0;
  logic [31:0] pwdata = 0;
  logic [31:0] prdata;
  logic pready, pslverr, irq;
  logic [NUM_CH-1:0] ch_clk_en, ch_busy;
  clk_ratio_ctrl #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .per_clk(per_clk), .clkrst_b(clkrst_b), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .ch_clk_en(ch_clk_en),
    .ch_busy(ch_busy), .irq(irq)
  );
  always #5 per_clk = ~per_clk;
  int n_pass = 0, n_total = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask
  // Reference model: each channel keeps the absolute cycle of its next
  // pulse; a pending ratio takes effect at that pulse and pushes the
  // following pulse out by the settle gap plus one full new period.
  int cyc = 0;
  int m_cur[NUM_CH], m_newr[NUM_CH], m_next[NUM_CH], m_send[NUM_CH];
  bit m_pend[NUM_CH], m_busy[NUM_CH];
  logic [NUM_CH-1:0] m_irqstat = '0;
  bit m_irq = 0;
  typedef logic [2*NUM_CH:0] exp_t;
  typedef struct packed {logic err; logic [31:0] rd;} apb_t;
  exp_t q_en[$];
  apb_t q_apb[$];
  function automatic bit exp_err(input logic [11:0] a, input bit w);
    int wd;
    wd = int'(a[11:2]);
    if (wd < NUM_CH) return w && m_busy[wd];
    if (wd == 'h40) return w;
    if (wd == 'h41) return 0;
    return 1;
  endfunction
  function automatic logic [31:0] exp_rd(input logic [11:0] a, input bit w);
    int wd;
    logic [31:0] r;
    wd = int'(a[11:2]);
    r = '0;
    if (w) return '0;
    if (wd < NUM_CH) return m_busy[wd] ? m_newr[wd] : m_cur[wd];
    if (wd == 'h40) begin
      for (int i = 0; i < NUM_CH; i++) r[i] = m_busy[i];
      return r;
    end
    if (wd == 'h41) return 32'(m_irqstat);
    return '0;
  endfunction
  always @(posedge per_clk) begin
    exp_t e;
    bit wr;
    int wd, v;
    logic [NUM_CH-1:0] done, clr;
    cyc++;
    e = '0;
    if (!clkrst_b) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cur[i] = 0; m_newr[i] = 0; m_pend[i] = 0; m_busy[i] = 0;
        m_send[i] = -1; m_next[i] = cyc + 1;
      end
      m_irqstat = '0;
      m_irq = 0;
    end else begin
      wr = psel && penable && pwrite && !exp_err(paddr, 1);
      wd = int'(paddr[11:2]);
      v = int'(pwdata[DIV_W-1:0]);
      done = '0;
      clr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cyc == m_next[i]) begin
          e[i] = 1'b1;
          if (m_pend[i]) begin
            m_cur[i] = m_newr[i];
            m_pend[i] = 0;
            m_send[i] = cyc + SETTLE_CYC;
            m_next[i] = m_send[i] + m_cur[i] + 1;
          end else m_next[i] = cyc + m_cur[i] + 1;
        end
        done[i] = cyc == m_send[i];
      end
      if (wr && wd < NUM_CH && v != m_cur[wd]) begin
        m_pend[wd] = 1;
        m_newr[wd] = v;
      end
      if (wr && wd == 'h41) clr = pwdata[NUM_CH-1:0];
`ifdef CLK_RATIO_IRQ_EN
      m_irq = |m_irqstat;
      m_irqstat = (m_irqstat & ~clr) | done;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        m_busy[i] = m_pend[i] || cyc < m_send[i];
        e[NUM_CH+i] = m_busy[i];
      end
      e[2*NUM_CH] = m_irq;
    end
    q_en.push_back(e);
  end
  always begin
    exp_t e;
    apb_t a;
    @(negedge per_clk);
    #1;
    if (q_en.size() > 0) begin
      e = q_en.pop_front();
      if (!clkrst_b) e = '0;
      chk("ch_clk_en", 32'(ch_clk_en), 32'(e[NUM_CH-1:0]));
      chk("ch_busy", 32'(ch_busy), 32'(e[2*NUM_CH-1:NUM_CH]));
      chk("irq", 32'(irq), 32'(e[2*NUM_CH]));
    end
    if (psel && penable) begin
      if (q_apb.size() == 0) begin
        n_total++;
        $display("FAIL apb_scoreboard: access at %0t with nothing expected", $time);
      end else begin
        a = q_apb.pop_front();
        chk("pslverr", 32'(pslverr), 32'(a.err));
        chk("prdata", prdata, a.rd);
        chk("pready", 32'(pready), 32'd1);
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge per_clk);
  endtask
  task automatic apb(input bit w, input logic [11:0] a, input logic [31:0] d);
    @(negedge per_clk);
    psel = 1; pwrite = w; paddr = a; pwdata = d; penable = 0;
    @(negedge per_clk);
    penable = 1;
    q_apb.push_back({exp_err(a, w), exp_rd(a, w)});
    @(negedge per_clk);
    psel = 0; penable = 0; pwrite = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    idle(3);
    chk("prdata_in_reset", prdata, 32'd0);
    clkrst_b = 1;
    idle(4);
    apb(0, 12'h000, 0);
    apb(0, 12'h100, 0);
    apb(1, 12'h000, 3);
    apb(0, 12'h100, 0);
    idle(14);
    apb(1, 12'h004, 7);
    idle(20);
    apb(1, 12'h004, 2);
    apb(0, 12'h004, 0);
    idle(14);
    apb(1, 12'h000, 15);
    idle(30);
    apb(1, 12'h000, 9);
    apb(1, 12'h000, 5);
    apb(0, 12'h000, 0);
    idle(40);
    apb(1, 12'h000, 9);
    idle(5);
    apb(1, 12'h200, 1);
    apb(1, 12'h100, 3);
    apb(0, 12'h200, 0);
    apb(0, 12'h0FC, 0);
    apb(0, 12'h003, 0);
    apb(1, 12'h000, 2);
    idle(20);
    apb(0, 12'h104, 0);
    apb(1, 12'h104, 1);
    apb(0, 12'h104, 0);
    apb(1, 12'h000, 7);
    k = 0;
    while (k < 40 && !(m_pend[0] && m_next[0] + SETTLE_CYC == cyc + 3)) begin
      @(negedge per_clk);
      k++;
    end
    if (k == 40) begin
      n_total++;
      $display("FAIL set_clear_window: switch edge not reached in 40 cycles");
    end
    apb(1, 12'h104, 1);
    apb(0, 12'h104, 0);
    apb(1, 12'h104, 3);
    apb(0, 12'h104, 0);
    apb(1, 12'h004, 9);
    clkrst_b = 0;
    idle(3);
    chk("prdata_in_reset2", prdata, 32'd0);
    clkrst_b = 1;
    idle(3);
    apb(0, 12'h004, 0);
    apb(0, 12'h100, 0);
    for (int n = 0; n < 250; n++) begin
      int s;
      logic [11:0] a;
      logic [31:0] d;
      s = $urandom_range(0, 9);
      d = $urandom;
      if (s < 6) a = 12'(4 * (s % NUM_CH));
      else if (s == 6) a = 12'h100;
      else if (s == 7) a = 12'h104;
      else a = 12'h200 + 12'(4 * $urandom_range(0, 63));
      a[1:0] = 2'($urandom_range(0, 3));
      apb($urandom_range(0, 3) != 0, a, d);
      idle($urandom_range(0, 5));
    end
    idle(30);
    chk("apb_queue_drained", 32'(q_apb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
